wbstage: RTL and testbench

Writeback stage of the pipelined datapath: the writer side of the register file that `decstage` reads. It accepts completed results from the ALU path and the memory path through valid/ready handshakes, queues them in a small in-order buffer, and drains one result per cycle onto the register-file write port. It also gives the decode stage pending-write lookup and forwarding for its two read addresses.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wbstage.sv | 101 ++++++++++
 tb/tb_wbstage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage.
package wb_pkg;

   localparam int unsigned DW_DEF   = 32;
   localparam int unsigned AW_DEF   = 5;
   localparam int unsigned ZERO_REG = 0;

   typedef struct packed {
      logic [AW_DEF-1:0] dst;
      logic [DW_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer; exposes every slot plus the head index so the
// lookup CAM can walk entries oldest to youngest.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned AW    = AW_DEF,
   localparam int unsigned PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [AW-1:0] push_dst,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] head_idx,
   output logic          ent_valid [DEPTH],
   output logic [AW-1:0] ent_dst   [DEPTH],
   output logic [DW-1:0] ent_data  [DEPTH]
);

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;

   assign empty    = (count == '0);
   assign full     = (count == (PW+1)'(DEPTH));
   assign head_idx = rd_ptr;

   // Caller guarantees no push when full and no pop when empty, so the
   // write and read slots never coincide within one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            ent_valid[i] <= 1'b0;
            ent_dst[i]   <= '0;
            ent_data[i]  <= '0;
         end
      end else begin
         if (push) begin
            ent_valid[wr_ptr] <= 1'b1;
            ent_dst[wr_ptr]   <= push_dst;
            ent_data[wr_ptr]  <= push_data;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + PW'(1);
         end
         if (push && !pop)
            count <= count + (PW+1)'(1);
         else if (pop && !push)
            count <= count - (PW+1)'(1);
      end
   end

endmodule

// File: rtl/wbstage.sv
// Writeback stage: arbitrates ALU/memory results into an in-order buffer,
// drains one per cycle to the register file, and serves pending/forward lookups.
module wbstage
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = DW_DEF,
   parameter int unsigned AW    = AW_DEF
) (
   input  logic          Clk,
   input  logic          Rst_n,
   input  logic          Alu_Valid,
   input  logic [AW-1:0] Alu_Dst,
   input  logic [DW-1:0] Alu_Data,
   output logic          Alu_Ready,
   input  logic          Mem_Valid,
   input  logic [AW-1:0] Mem_Dst,
   input  logic [DW-1:0] Mem_Data,
   output logic          Mem_Ready,
   input  logic          WB_Hold,
   output logic          RF_WrEn,
   output logic [AW-1:0] RF_Awr,
   output logic [DW-1:0] RF_Din,
   input  logic [AW-1:0] Qa,
   input  logic [AW-1:0] Qb,
   output logic          Pend_A,
   output logic          Pend_B,
   output logic [DW-1:0] Fwd_A,
   output logic [DW-1:0] Fwd_B
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          take;
   logic [AW-1:0] push_dst;
   logic [DW-1:0] push_data;
   logic [PW-1:0] head_idx;
   logic          ent_valid [DEPTH];
   logic [AW-1:0] ent_dst   [DEPTH];
   logic [DW-1:0] ent_data  [DEPTH];

   // Memory wins arbitration; readies are forced low while in reset.
   assign Mem_Ready = Rst_n && !full;
   assign Alu_Ready = Rst_n && !full && !Mem_Valid;

   assign take      = (Mem_Valid && Mem_Ready) || (Alu_Valid && Alu_Ready);
   assign push_dst  = Mem_Valid ? Mem_Dst  : Alu_Dst;
   assign push_data = Mem_Valid ? Mem_Data : Alu_Data;
   // Register 0 results complete the handshake but are dropped here.
   assign push      = take && (push_dst != AW'(ZERO_REG));

   assign RF_WrEn = !empty && !WB_Hold;
   assign pop     = RF_WrEn;
   assign RF_Awr  = empty ? '0 : ent_dst[head_idx];
   assign RF_Din  = empty ? '0 : ent_data[head_idx];

   wb_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .AW    (AW)
   ) u_fifo (
      .clk       (Clk),
      .rst_n     (Rst_n),
      .push      (push),
      .push_dst  (push_dst),
      .push_data (push_data),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .head_idx  (head_idx),
      .ent_valid (ent_valid),
      .ent_dst   (ent_dst),
      .ent_data  (ent_data)
   );

   // Walk oldest to youngest so the last hit is the youngest match.
   always_comb begin
      logic [PW-1:0] idx;
      Pend_A = 1'b0;
      Pend_B = 1'b0;
      Fwd_A  = '0;
      Fwd_B  = '0;
      idx    = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         idx = head_idx + PW'(k);
         if (ent_valid[idx] && (Qa != AW'(ZERO_REG)) && (ent_dst[idx] == Qa)) begin
            Pend_A = 1'b1;
            Fwd_A  = ent_data[idx];
         end
         if (ent_valid[idx] && (Qb != AW'(ZERO_REG)) && (ent_dst[idx] == Qb)) begin
            Pend_B = 1'b1;
            Fwd_B  = ent_data[idx];
         end
      end
   end

endmodule

// File: tb/tb_wbstage.sv
// Directed bench for wbstage: one task per scenario with hand-computed expectations.
module tb_wbstage;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        Alu_Valid, Mem_Valid, WB_Hold;
   logic [4:0]  Alu_Dst, Mem_Dst, Qa, Qb;
   logic [31:0] Alu_Data, Mem_Data;
   logic        Alu_Ready, Mem_Ready, RF_WrEn, Pend_A, Pend_B;
   logic [4:0]  RF_Awr;
   logic [31:0] RF_Din, Fwd_A, Fwd_B;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   wbstage #(.DEPTH(4), .DW(32), .AW(5)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Alu_Valid(Alu_Valid), .Alu_Dst(Alu_Dst), .Alu_Data(Alu_Data), .Alu_Ready(Alu_Ready),
      .Mem_Valid(Mem_Valid), .Mem_Dst(Mem_Dst), .Mem_Data(Mem_Data), .Mem_Ready(Mem_Ready),
      .WB_Hold(WB_Hold), .RF_WrEn(RF_WrEn), .RF_Awr(RF_Awr), .RF_Din(RF_Din),
      .Qa(Qa), .Qb(Qb), .Pend_A(Pend_A), .Pend_B(Pend_B), .Fwd_A(Fwd_A), .Fwd_B(Fwd_B)
   );

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0; Alu_Valid = 0; Mem_Valid = 0; WB_Hold = 0;
      Alu_Dst = 0; Alu_Data = 0; Mem_Dst = 0; Mem_Data = 0; Qa = 0; Qb = 0;
      tick(); tick();
      n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL rst_wren got %b want 0", RF_WrEn); end
      n_tests++; if (Mem_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_ready got %b want 0", Mem_Ready); end
      n_tests++; if (Alu_Ready !== 1'b0) begin n_fail++; $display("FAIL rst_alu_ready got %b want 0", Alu_Ready); end
      n_tests++; if (RF_Awr !== 5'd0 || RF_Din !== 32'd0) begin n_fail++; $display("FAIL rst_rf got %0h/%0h want 0/0", RF_Awr, RF_Din); end
      Rst_n = 1'b1;
      #1;
      n_tests++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready got %b%b want 11", Mem_Ready, Alu_Ready); end
   endtask

   task automatic test_single();
      Alu_Valid = 1; Alu_Dst = 5'd3; Alu_Data = 32'h11; Qa = 5'd3;
      #1;
      n_tests++; if (Alu_Ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", Alu_Ready); end
      tick();
      Alu_Valid = 0;
      #1;
      n_tests++; if (RF_WrEn !== 1'b1) begin n_fail++; $display("FAIL single_wren got %b want 1", RF_WrEn); end
      n_tests++; if (RF_Awr !== 5'd3) begin n_fail++; $display("FAIL single_awr got %0d want 3", RF_Awr); end
      n_tests++; if (RF_Din !== 32'h11) begin n_fail++; $display("FAIL single_din got %0h want 11", RF_Din); end
      n_tests++; if (Pend_A !== 1'b1 || Fwd_A !== 32'h11) begin n_fail++; $display("FAIL single_pend got %b/%0h want 1/11", Pend_A, Fwd_A); end
      tick();
      n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b want 0", RF_WrEn); end
      n_tests++; if (Pend_A !== 1'b0 || Fwd_A !== 32'h0) begin n_fail++; $display("FAIL single_unpend got %b/%0h want 0/0", Pend_A, Fwd_A); end
      Qa = 0;
   endtask

   task automatic test_arbitration();
      Mem_Valid = 1; Mem_Dst = 5'd4; Mem_Data = 32'hAA;
      Alu_Valid = 1; Alu_Dst = 5'd5; Alu_Data = 32'hBB;
      #1;
      n_tests++; if (Mem_Ready !== 1'b1 || Alu_Ready !== 1'b0) begin n_fail++; $display("FAIL arb_ready got mem=%b alu=%b want 1/0", Mem_Ready, Alu_Ready); end
      tick();
      Mem_Valid = 0;
      #1;
      n_tests++; if (Alu_Ready !== 1'b1) begin n_fail++; $display("FAIL arb_alu_ready got %b want 1", Alu_Ready); end
      n_tests++; if (RF_WrEn !== 1'b1 || RF_Awr !== 5'd4 || RF_Din !== 32'hAA) begin n_fail++; $display("FAIL arb_first got %b/%0d/%0h want 1/4/aa", RF_WrEn, RF_Awr, RF_Din); end
      tick();
      Alu_Valid = 0;
      #1;
      n_tests++; if (RF_WrEn !== 1'b1 || RF_Awr !== 5'd5 || RF_Din !== 32'hBB) begin n_fail++; $display("FAIL arb_second got %b/%0d/%0h want 1/5/bb", RF_WrEn, RF_Awr, RF_Din); end
      tick();
      n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL arb_empty got %b want 0", RF_WrEn); end
   endtask

   task automatic test_full_and_wrap();
      WB_Hold = 1;
      for (int i = 0; i < 4; i++) begin
         Alu_Valid = 1; Alu_Dst = 5'(8 + i); Alu_Data = 32'h100 + 32'(i);
         tick();
      end
      Alu_Valid = 0;
      Mem_Valid = 1; Mem_Dst = 5'd30; Mem_Data = 32'hDEAD;
      #1;
      n_tests++; if (Mem_Ready !== 1'b0 || Alu_Ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b%b want 00", Mem_Ready, Alu_Ready); end
      n_tests++; if (RF_WrEn !== 1'b0 || RF_Awr !== 5'd8) begin n_fail++; $display("FAIL full_hold got %b/%0d want 0/8", RF_WrEn, RF_Awr); end
      WB_Hold = 0;
      #1;
      n_tests++; if (Mem_Ready !== 1'b0) begin n_fail++; $display("FAIL full_drain_ready got %b want 0", Mem_Ready); end
      Mem_Valid = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_tests++; if (RF_WrEn !== 1'b1 || RF_Awr !== 5'(8 + i) || RF_Din !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL drain_%0d got %b/%0d/%0h want 1/%0d/%0h", i, RF_WrEn, RF_Awr, RF_Din, 8 + i, 32'h100 + 32'(i)); end
         tick();
      end
      n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL drain_done got %b want 0", RF_WrEn); end
      // Streaming push/pop across the pointer wrap.
      for (int i = 0; i < 4; i++) begin
         Alu_Valid = 1; Alu_Dst = 5'(12 + i); Alu_Data = 32'h200 + 32'(i);
         tick();
         n_tests++; if (RF_WrEn !== 1'b1 || RF_Awr !== 5'(12 + i) || RF_Din !== 32'h200 + 32'(i)) begin n_fail++; $display("FAIL wrap_%0d got %b/%0d/%0h want 1/%0d/%0h", i, RF_WrEn, RF_Awr, RF_Din, 12 + i, 32'h200 + 32'(i)); end
      end
      Alu_Valid = 0;
      tick();
      n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL wrap_done got %b want 0", RF_WrEn); end
   endtask

   task automatic test_forward();
      WB_Hold = 1; Qa = 5'd7; Qb = 5'd7;
      Alu_Valid = 1; Alu_Dst = 5'd7; Alu_Data = 32'd1;
      tick();
      n_tests++; if (Pend_A !== 1'b1 || Fwd_A !== 32'd1) begin n_fail++; $display("FAIL fwd_one got %b/%0h want 1/1", Pend_A, Fwd_A); end
      Alu_Data = 32'd2;
      tick();
      Alu_Valid = 0;
      #1;
      n_tests++; if (Pend_A !== 1'b1 || Fwd_A !== 32'd2) begin n_fail++; $display("FAIL fwd_young_a got %b/%0h want 1/2", Pend_A, Fwd_A); end
      n_tests++; if (Pend_B !== 1'b1 || Fwd_B !== 32'd2) begin n_fail++; $display("FAIL fwd_young_b got %b/%0h want 1/2", Pend_B, Fwd_B); end
      WB_Hold = 0;
      tick();
      n_tests++; if (Pend_A !== 1'b1 || Fwd_A !== 32'd2) begin n_fail++; $display("FAIL fwd_after_pop got %b/%0h want 1/2", Pend_A, Fwd_A); end
      tick();
      n_tests++; if (Pend_A !== 1'b0 || Fwd_A !== 32'd0 || Pend_B !== 1'b0) begin n_fail++; $display("FAIL fwd_clear got %b/%0h/%b want 0/0/0", Pend_A, Fwd_A, Pend_B); end
      Qb = 0;
   endtask

   task automatic test_zero_reg();
      Qa = 5'd0;
      Alu_Valid = 1; Alu_Dst = 5'd0; Alu_Data = 32'hFF;
      #1;
      n_tests++; if (Alu_Ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", Alu_Ready); end
      tick();
      Alu_Valid = 0;
      #1;
      n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL zero_wren got %b want 0", RF_WrEn); end
      n_tests++; if (Pend_A !== 1'b0 || Fwd_A !== 32'd0) begin n_fail++; $display("FAIL zero_pend got %b/%0h want 0/0", Pend_A, Fwd_A); end
   endtask

   task automatic test_reset_mid_burst();
      WB_Hold = 1; Qa = 5'd21;
      for (int i = 0; i < 3; i++) begin
         Alu_Valid = 1; Alu_Dst = 5'(20 + i); Alu_Data = 32'h300 + 32'(i);
         tick();
      end
      Alu_Valid = 0;
      #1;
      n_tests++; if (RF_Awr !== 5'd20 || Pend_A !== 1'b1) begin n_fail++; $display("FAIL mid_prefill got %0d/%b want 20/1", RF_Awr, Pend_A); end
      WB_Hold = 0;
      #1;
      Rst_n = 0;
      #1;
      n_tests++; if (RF_WrEn !== 1'b0 || RF_Awr !== 5'd0 || RF_Din !== 32'd0) begin n_fail++; $display("FAIL mid_rst_rf got %b/%0d/%0h want 0/0/0", RF_WrEn, RF_Awr, RF_Din); end
      n_tests++; if (Pend_A !== 1'b0 || Fwd_A !== 32'd0) begin n_fail++; $display("FAIL mid_rst_pend got %b/%0h want 0/0", Pend_A, Fwd_A); end
      n_tests++; if (Mem_Ready !== 1'b0 || Alu_Ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready got %b%b want 00", Mem_Ready, Alu_Ready); end
      #1;
      Rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++; if (RF_WrEn !== 1'b0) begin n_fail++; $display("FAIL mid_post_%0d got %b want 0", i, RF_WrEn); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_arbitration();
      test_full_and_wrap();
      test_forward();
      test_zero_reg();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
